control_pipeline: RTL and testbench

Pipelined successor to the single-cycle MIPS control decoder. It decodes the ID-stage instruction and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards, flushes on redirect, and generates EX-operand forwarding selects. It sits between the IF/ID register and the datapath stage registers.

---
 rtl/control_pipeline.sv | 217 +++++++++++++++++++++
 tb/tb_control_pipeline.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_pipeline.sv
// Pipelined MIPS control. Decodes the ID instruction and carries the control
// bundle through ID/EX, EX/MEM and MEM/WB. Also detects load-use hazards,
// flushes on redirect, and registers the EX operand forward selects.
module control_pipeline #(
    parameter int REG_AW  = 5,
    parameter int ALU_CW  = 5,
    parameter bit HAS_EXT = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [5:0]        op_code,
    input  logic [5:0]        funct_code,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    input  logic              freeze,
    input  logic              redirect,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_write,
    output logic              ex_load_upper,
    output logic              ex_jal,
    output logic [1:0]        ex_jump,
    output logic              ex_branch,
    output logic [3:0]        ex_bcu_control,
    output logic [ALU_CW-1:0] ex_alu_control,
    output logic              ex_alu_src,
    output logic [REG_AW-1:0] ex_dest,
    output logic              mem_valid,
    output logic              mem_reg_write,
    output logic              mem_mem_to_reg,
    output logic              mem_mem_write,
    output logic              mem_load_upper,
    output logic              mem_jal,
    output logic [1:0]        mem_jump,
    output logic              mem_branch,
    output logic [3:0]        mem_bcu_control,
    output logic [ALU_CW-1:0] mem_alu_control,
    output logic              mem_alu_src,
    output logic [REG_AW-1:0] mem_dest,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic              wb_mem_write,
    output logic              wb_load_upper,
    output logic              wb_jal,
    output logic [1:0]        wb_jump,
    output logic              wb_branch,
    output logic [3:0]        wb_bcu_control,
    output logic [ALU_CW-1:0] wb_alu_control,
    output logic              wb_alu_src,
    output logic [REG_AW-1:0] wb_dest,
    output logic              hazard_stall,
    output logic              flush_if_id,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              id_illegal
);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_write;
        logic              load_upper;
        logic              jal;
        logic [1:0]        jump;
        logic              branch;
        logic [3:0]        bcu_control;
        logic [ALU_CW-1:0] alu_control;
        logic              alu_src;
        logic [REG_AW-1:0] dest;
    } ctrl_t;

    localparam logic [ALU_CW-1:0] ALU_ADD = ALU_CW'(0);
    localparam logic [ALU_CW-1:0] ALU_SUB = ALU_CW'(1);
    localparam logic [ALU_CW-1:0] ALU_AND = ALU_CW'(2);
    localparam logic [ALU_CW-1:0] ALU_OR  = ALU_CW'(3);
    localparam logic [ALU_CW-1:0] ALU_SLT = ALU_CW'(4);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0c, OP_ORI  = 6'h0d, OP_LUI  = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2b;
    localparam logic [5:0] FN_JR    = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24, FN_SLT  = 6'h2a;

    ctrl_t       w_dec, r_ex, r_mem, r_wb;
    logic        w_legal, w_reg_dst, w_rt_reader, w_hazard;
    logic [1:0]  w_fwd_a, w_fwd_b, r_fwd_a, r_fwd_b;

    always_comb begin
        w_dec     = '0;
        w_legal   = 1'b0;
        w_reg_dst = 1'b0;
        case (op_code)
            OP_RTYPE: begin
                case (funct_code)
                    FN_ADDU: begin
                        w_legal = 1'b1; w_dec.reg_write = 1'b1; w_reg_dst = 1'b1;
                        w_dec.alu_control = ALU_ADD;
                    end
                    FN_SUBU: if (HAS_EXT) begin
                        w_legal = 1'b1; w_dec.reg_write = 1'b1; w_reg_dst = 1'b1;
                        w_dec.alu_control = ALU_SUB;
                    end
                    FN_AND: if (HAS_EXT) begin
                        w_legal = 1'b1; w_dec.reg_write = 1'b1; w_reg_dst = 1'b1;
                        w_dec.alu_control = ALU_AND;
                    end
                    FN_SLT: if (HAS_EXT) begin
                        w_legal = 1'b1; w_dec.reg_write = 1'b1; w_reg_dst = 1'b1;
                        w_dec.alu_control = ALU_SLT;
                    end
                    FN_JR: begin
                        w_legal = 1'b1; w_dec.jump = 2'b10;
                    end
                    default: ;
                endcase
            end
            OP_ADDIU: begin
                w_legal = 1'b1; w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1;
                w_dec.alu_control = ALU_ADD;
            end
            OP_ANDI: if (HAS_EXT) begin
                w_legal = 1'b1; w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1;
                w_dec.alu_control = ALU_AND;
            end
            OP_ORI: begin
                w_legal = 1'b1; w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1;
                w_dec.alu_control = ALU_OR;
            end
            OP_LUI: begin
                w_legal = 1'b1; w_dec.reg_write = 1'b1; w_dec.load_upper = 1'b1;
            end
            OP_LW: begin
                w_legal = 1'b1; w_dec.reg_write = 1'b1; w_dec.mem_to_reg = 1'b1;
                w_dec.alu_src = 1'b1; w_dec.alu_control = ALU_ADD;
            end
            OP_SW: begin
                w_legal = 1'b1; w_dec.mem_write = 1'b1; w_dec.alu_src = 1'b1;
                w_dec.alu_control = ALU_ADD;
            end
            OP_BEQ: begin
                w_legal = 1'b1; w_dec.branch = 1'b1; w_dec.bcu_control = 4'b0001;
                w_dec.alu_control = ALU_SUB;
            end
            OP_BNE: begin
                w_legal = 1'b1; w_dec.branch = 1'b1; w_dec.bcu_control = 4'b0010;
                w_dec.alu_control = ALU_SUB;
            end
            OP_J: if (HAS_EXT) begin
                w_legal = 1'b1; w_dec.jump = 2'b01;
            end
            OP_JAL: begin
                w_legal = 1'b1; w_dec.jump = 2'b01; w_dec.jal = 1'b1;
                w_dec.reg_write = 1'b1;
            end
            default: ;
        endcase
        w_dec.dest  = w_dec.jal ? '1 : (w_reg_dst ? rd : rt);
        // Writes to r0 are architecturally dropped, so never advertise them.
        if (w_dec.dest == '0) w_dec.reg_write = 1'b0;
        w_dec.valid = w_legal;
        if (!(id_valid && w_legal)) w_dec = '0;
    end

    assign id_illegal  = id_valid && !w_legal;
    assign w_rt_reader = ((op_code == OP_RTYPE) && (funct_code != FN_JR)) ||
                         (op_code == OP_SW) || (op_code == OP_BEQ) || (op_code == OP_BNE);
    assign w_hazard    = id_valid && r_ex.valid && r_ex.mem_to_reg && (r_ex.dest != '0) &&
                         ((r_ex.dest == rs) || (w_rt_reader && (r_ex.dest == rt)));
    assign hazard_stall = w_hazard;
    assign flush_if_id  = redirect && !freeze;

    // Evaluated one stage early: what sits in EX/ID-EX now will be in MEM/WB
    // by the time this instruction occupies EX.
    assign w_fwd_a = (rs != '0 && r_ex.valid && r_ex.reg_write && r_ex.dest == rs)    ? 2'b10 :
                     (rs != '0 && r_mem.valid && r_mem.reg_write && r_mem.dest == rs) ? 2'b01 : 2'b00;
    assign w_fwd_b = (rt != '0 && r_ex.valid && r_ex.reg_write && r_ex.dest == rt)    ? 2'b10 :
                     (rt != '0 && r_mem.valid && r_mem.reg_write && r_mem.dest == rt) ? 2'b01 : 2'b00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ex    <= '0;
            r_mem   <= '0;
            r_wb    <= '0;
            r_fwd_a <= 2'b00;
            r_fwd_b <= 2'b00;
        end else if (!freeze) begin
            r_mem <= r_ex;
            r_wb  <= r_mem;
            if (redirect || w_hazard) begin
                r_ex    <= '0;
                r_fwd_a <= 2'b00;
                r_fwd_b <= 2'b00;
            end else begin
                r_ex    <= w_dec;
                r_fwd_a <= w_dec.valid ? w_fwd_a : 2'b00;
                r_fwd_b <= w_dec.valid ? w_fwd_b : 2'b00;
            end
        end
    end

    assign fwd_a = r_fwd_a;
    assign fwd_b = r_fwd_b;

    assign {ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_load_upper, ex_jal,
            ex_jump, ex_branch, ex_bcu_control, ex_alu_control, ex_alu_src, ex_dest} = r_ex;
    assign {mem_valid, mem_reg_write, mem_mem_to_reg, mem_mem_write, mem_load_upper, mem_jal,
            mem_jump, mem_branch, mem_bcu_control, mem_alu_control, mem_alu_src, mem_dest} = r_mem;
    assign {wb_valid, wb_reg_write, wb_mem_to_reg, wb_mem_write, wb_load_upper, wb_jal,
            wb_jump, wb_branch, wb_bcu_control, wb_alu_control, wb_alu_src, wb_dest} = r_wb;

endmodule

// File: tb/tb_control_pipeline.sv
// Self-checking bench for control_pipeline: directed scenarios plus a random
// run against a table-driven reference model of the pipeline rules.
module tb_control_pipeline;
    localparam int AW = 5;
    localparam int CW = 5;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    typedef struct packed {
        logic valid, rw, m2r, mw, lu, jal;
        logic [1:0] jump;
        logic br;
        logic [3:0] bcu;
        logic [CW-1:0] alu;
        logic src;
        logic [AW-1:0] dest;
    } bnd_t;

    typedef struct packed {
        logic [5:0] op, fn;
        logic ext, rw, rdsel, m2r, mw, lu, jal;
        logic [1:0] jump;
        logic br;
        logic [3:0] bcu;
        logic [CW-1:0] alu;
        logic src;
    } ent_t;

    ent_t tbl [15];

    logic clk, reset_n, id_valid, freeze, redirect;
    logic [5:0] op_code, funct_code;
    logic [AW-1:0] rs, rt, rd;

    logic ex_valid[2], ex_reg_write[2], ex_mem_to_reg[2], ex_mem_write[2], ex_load_upper[2], ex_jal[2];
    logic [1:0] ex_jump[2];
    logic ex_branch[2], ex_alu_src[2];
    logic [3:0] ex_bcu_control[2];
    logic [CW-1:0] ex_alu_control[2];
    logic [AW-1:0] ex_dest[2];
    logic mem_valid[2], mem_reg_write[2], mem_mem_to_reg[2], mem_mem_write[2], mem_load_upper[2], mem_jal[2];
    logic [1:0] mem_jump[2];
    logic mem_branch[2], mem_alu_src[2];
    logic [3:0] mem_bcu_control[2];
    logic [CW-1:0] mem_alu_control[2];
    logic [AW-1:0] mem_dest[2];
    logic wb_valid[2], wb_reg_write[2], wb_mem_to_reg[2], wb_mem_write[2], wb_load_upper[2], wb_jal[2];
    logic [1:0] wb_jump[2];
    logic wb_branch[2], wb_alu_src[2];
    logic [3:0] wb_bcu_control[2];
    logic [CW-1:0] wb_alu_control[2];
    logic [AW-1:0] wb_dest[2];
    logic hazard_stall[2], flush_if_id[2], id_illegal[2];
    logic [1:0] fwd_a[2], fwd_b[2];
    bnd_t a_ex[2], a_mem[2], a_wb[2];

    int n_cmp = 0;
    int n_err = 0;

    // Instance 0 decodes the extended set, instance 1 does not.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        control_pipeline #(.REG_AW(AW), .ALU_CW(CW), .HAS_EXT(g == 0 ? 1'b1 : 1'b0)) u_dut (
            .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .op_code(op_code),
            .funct_code(funct_code), .rs(rs), .rt(rt), .rd(rd), .freeze(freeze), .redirect(redirect),
            .ex_valid(ex_valid[g]), .ex_reg_write(ex_reg_write[g]), .ex_mem_to_reg(ex_mem_to_reg[g]),
            .ex_mem_write(ex_mem_write[g]), .ex_load_upper(ex_load_upper[g]), .ex_jal(ex_jal[g]),
            .ex_jump(ex_jump[g]), .ex_branch(ex_branch[g]), .ex_bcu_control(ex_bcu_control[g]),
            .ex_alu_control(ex_alu_control[g]), .ex_alu_src(ex_alu_src[g]), .ex_dest(ex_dest[g]),
            .mem_valid(mem_valid[g]), .mem_reg_write(mem_reg_write[g]), .mem_mem_to_reg(mem_mem_to_reg[g]),
            .mem_mem_write(mem_mem_write[g]), .mem_load_upper(mem_load_upper[g]), .mem_jal(mem_jal[g]),
            .mem_jump(mem_jump[g]), .mem_branch(mem_branch[g]), .mem_bcu_control(mem_bcu_control[g]),
            .mem_alu_control(mem_alu_control[g]), .mem_alu_src(mem_alu_src[g]), .mem_dest(mem_dest[g]),
            .wb_valid(wb_valid[g]), .wb_reg_write(wb_reg_write[g]), .wb_mem_to_reg(wb_mem_to_reg[g]),
            .wb_mem_write(wb_mem_write[g]), .wb_load_upper(wb_load_upper[g]), .wb_jal(wb_jal[g]),
            .wb_jump(wb_jump[g]), .wb_branch(wb_branch[g]), .wb_bcu_control(wb_bcu_control[g]),
            .wb_alu_control(wb_alu_control[g]), .wb_alu_src(wb_alu_src[g]), .wb_dest(wb_dest[g]),
            .hazard_stall(hazard_stall[g]), .flush_if_id(flush_if_id[g]),
            .fwd_a(fwd_a[g]), .fwd_b(fwd_b[g]), .id_illegal(id_illegal[g])
        );
        assign a_ex[g]  = {ex_valid[g], ex_reg_write[g], ex_mem_to_reg[g], ex_mem_write[g], ex_load_upper[g],
                           ex_jal[g], ex_jump[g], ex_branch[g], ex_bcu_control[g], ex_alu_control[g],
                           ex_alu_src[g], ex_dest[g]};
        assign a_mem[g] = {mem_valid[g], mem_reg_write[g], mem_mem_to_reg[g], mem_mem_write[g], mem_load_upper[g],
                           mem_jal[g], mem_jump[g], mem_branch[g], mem_bcu_control[g], mem_alu_control[g],
                           mem_alu_src[g], mem_dest[g]};
        assign a_wb[g]  = {wb_valid[g], wb_reg_write[g], wb_mem_to_reg[g], wb_mem_write[g], wb_load_upper[g],
                           wb_jal[g], wb_jump[g], wb_branch[g], wb_bcu_control[g], wb_alu_control[g],
                           wb_alu_src[g], wb_dest[g]};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    bnd_t       mst [3];
    logic [1:0] mfa, mfb;

    task automatic init_tbl();
        //          op     fn     ext rw rdsel m2r mw lu jal jump  br  bcu   alu   src
        tbl[0]  = '{6'h00, 6'h21, F, T, T, F, F, F, F, 2'b00, F, 4'h0, 5'd0, F}; // addu
        tbl[1]  = '{6'h00, 6'h23, T, T, T, F, F, F, F, 2'b00, F, 4'h0, 5'd1, F}; // subu
        tbl[2]  = '{6'h00, 6'h24, T, T, T, F, F, F, F, 2'b00, F, 4'h0, 5'd2, F}; // and
        tbl[3]  = '{6'h00, 6'h2a, T, T, T, F, F, F, F, 2'b00, F, 4'h0, 5'd4, F}; // slt
        tbl[4]  = '{6'h00, 6'h08, F, F, F, F, F, F, F, 2'b10, F, 4'h0, 5'd0, F}; // jr
        tbl[5]  = '{6'h09, 6'h00, F, T, F, F, F, F, F, 2'b00, F, 4'h0, 5'd0, T}; // addiu
        tbl[6]  = '{6'h0c, 6'h00, T, T, F, F, F, F, F, 2'b00, F, 4'h0, 5'd2, T}; // andi
        tbl[7]  = '{6'h0d, 6'h00, F, T, F, F, F, F, F, 2'b00, F, 4'h0, 5'd3, T}; // ori
        tbl[8]  = '{6'h0f, 6'h00, F, T, F, F, F, T, F, 2'b00, F, 4'h0, 5'd0, F}; // lui
        tbl[9]  = '{6'h23, 6'h00, F, T, F, T, F, F, F, 2'b00, F, 4'h0, 5'd0, T}; // lw
        tbl[10] = '{6'h2b, 6'h00, F, F, F, F, T, F, F, 2'b00, F, 4'h0, 5'd0, T}; // sw
        tbl[11] = '{6'h04, 6'h00, F, F, F, F, F, F, F, 2'b00, T, 4'h1, 5'd1, F}; // beq
        tbl[12] = '{6'h05, 6'h00, F, F, F, F, F, F, F, 2'b00, T, 4'h2, 5'd1, F}; // bne
        tbl[13] = '{6'h02, 6'h00, T, F, F, F, F, F, F, 2'b01, F, 4'h0, 5'd0, F}; // j
        tbl[14] = '{6'h03, 6'h00, F, T, F, F, F, F, T, 2'b01, F, 4'h0, 5'd0, F}; // jal
    endtask

    function automatic bnd_t mdec(input logic [5:0] op, input logic [5:0] fn, input logic [AW-1:0] t,
                                  input logic [AW-1:0] d, input logic vld, input logic ext,
                                  output logic ill);
        bnd_t b = '0;
        ent_t e = '0;
        logic hit = 1'b0;
        for (int i = 0; i < 15; i++)
            if (!hit && tbl[i].op == op && (op != 6'h00 || tbl[i].fn == fn) && (!tbl[i].ext || ext)) begin
                e = tbl[i];
                hit = 1'b1;
            end
        ill = vld && !hit;
        if (vld && hit) begin
            b.valid = 1'b1; b.rw = e.rw; b.m2r = e.m2r; b.mw = e.mw; b.lu = e.lu; b.jal = e.jal;
            b.jump = e.jump; b.br = e.br; b.bcu = e.bcu; b.alu = e.alu; b.src = e.src;
            b.dest = e.jal ? 5'd31 : (e.rdsel ? d : t);
            if (b.dest == 5'd0) b.rw = 1'b0;
        end
        return b;
    endfunction

    // Producer in ID/EX now reaches MEM when the consumer reaches EX; MEM now reaches WB.
    function automatic logic [1:0] fsel(input logic [AW-1:0] r);
        if (r != 0 && mst[0].valid && mst[0].rw && mst[0].dest == r) return 2'b10;
        if (r != 0 && mst[1].valid && mst[1].rw && mst[1].dest == r) return 2'b01;
        return 2'b00;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drv(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [AW-1:0] s, input logic [AW-1:0] t, input logic [AW-1:0] d);
        id_valid = v; op_code = op; funct_code = fn; rs = s; rt = t; rd = d;
    endtask

    task automatic idle();
        drv(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
        freeze = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        drv(1'b1, 6'h3f, 6'h3f, 5'h1f, 5'h1f, 5'h1f);
        freeze = 1'b1;
        redirect = 1'b1;
        tick(); tick();
        for (int g = 0; g < 2; g++) begin
            n_cmp++;
            if ({a_ex[g], a_mem[g], a_wb[g], fwd_a[g], fwd_b[g]} !== '0) begin
                n_err++;
                $display("FAIL reset_zero dut%0d: got %h %h %h %b %b required all zero",
                         g, a_ex[g], a_mem[g], a_wb[g], fwd_a[g], fwd_b[g]);
            end
        end
        idle();
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if ({a_ex[0], a_mem[0], a_wb[0], fwd_a[0], fwd_b[0]} !== '0) begin
            n_err++;
            $display("FAIL first_edge_zero: got %h %h %h required zero", a_ex[0], a_mem[0], a_wb[0]);
        end
        drv(1'b1, 6'h00, 6'h21, 5'd1, 5'd2, 5'd3);
        tick();
        n_cmp++;
        if ({ex_valid[0], ex_reg_write[0], ex_dest[0], ex_alu_control[0]} !== {T, T, 5'd3, 5'd0}) begin
            n_err++;
            $display("FAIL first_addu: got v=%b rw=%b dest=%0d alu=%0d required 1 1 3 0",
                     ex_valid[0], ex_reg_write[0], ex_dest[0], ex_alu_control[0]);
        end
        idle();
    endtask

    task automatic test_sequence();
        logic [5:0] ops [10];
        logic [5:0] fns [10];
        bnd_t exp [10];
        logic ill;
        ops = '{6'h09, 6'h03, 6'h00, 6'h0f, 6'h23, 6'h0d, 6'h2b, 6'h00, 6'h04, 6'h05};
        fns = '{6'h00, 6'h00, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h21, 6'h00, 6'h00};
        for (int i = 0; i < 10; i++) exp[i] = mdec(ops[i], fns[i], AW'(10 + i), AW'(20 + i), T, T, ill);
        for (int i = 0; i < 12; i++) begin
            if (i < 10) drv(1'b1, ops[i], fns[i], 5'd1, AW'(10 + i), AW'(20 + i));
            else idle();
            tick();
            if (i < 10) begin
                n_cmp++;
                if (a_ex[0] !== exp[i]) begin
                    n_err++;
                    $display("FAIL seq_ex[%0d]: got %h required %h", i, a_ex[0], exp[i]);
                end
            end
            if (i >= 2) begin
                n_cmp++;
                if (a_wb[0] !== exp[i-2]) begin
                    n_err++;
                    $display("FAIL seq_wb[%0d]: got %h required %h", i - 2, a_wb[0], exp[i-2]);
                end
            end
            if (i == 1 || i == 8 || i == 9) begin
                n_cmp++;
                if ((i == 1 && ex_dest[0] !== 5'd31) || (i == 8 && ex_bcu_control[0] !== 4'b0001) ||
                    (i == 9 && ex_bcu_control[0] !== 4'b0010)) begin
                    n_err++;
                    $display("FAIL seq_const[%0d]: dest=%0d bcu=%b", i, ex_dest[0], ex_bcu_control[0]);
                end
            end
        end
    endtask

    task automatic test_load_use();
        idle(); tick(); tick(); tick();
        drv(1'b1, 6'h23, 6'h00, 5'd1, 5'd4, 5'd0);
        tick();
        drv(1'b1, 6'h00, 6'h21, 5'd4, 5'd2, 5'd6);
        #1;
        n_cmp++;
        if (hazard_stall[0] !== 1'b1) begin
            n_err++;
            $display("FAIL loaduse_stall: got %b required 1", hazard_stall[0]);
        end
        tick();
        n_cmp++;
        if ({ex_valid[0], hazard_stall[0]} !== 2'b00) begin
            n_err++;
            $display("FAIL loaduse_bubble: got ex_valid=%b stall=%b required 0 0", ex_valid[0], hazard_stall[0]);
        end
        tick();
        n_cmp++;
        if ({ex_valid[0], ex_reg_write[0], ex_dest[0], fwd_a[0], fwd_b[0], wb_mem_to_reg[0]} !==
            {T, T, 5'd6, 2'b01, 2'b00, T}) begin
            n_err++;
            $display("FAIL loaduse_fwd: got v=%b rw=%b dest=%0d fa=%b fb=%b wb_m2r=%b required 1 1 6 01 00 1",
                     ex_valid[0], ex_reg_write[0], ex_dest[0], fwd_a[0], fwd_b[0], wb_mem_to_reg[0]);
        end
        idle();
    endtask

    task automatic test_forward();
        idle(); tick(); tick(); tick();
        drv(1'b1, 6'h09, 6'h00, 5'd1, 5'd5, 5'd0);
        tick();
        drv(1'b1, 6'h00, 6'h23, 5'd5, 5'd5, 5'd7);
        tick();
        n_cmp++;
        if ({fwd_a[0], fwd_b[0]} !== 4'b1010) begin
            n_err++;
            $display("FAIL fwd_mem: got fa=%b fb=%b required 10 10", fwd_a[0], fwd_b[0]);
        end
        idle(); tick(); tick(); tick();
        drv(1'b1, 6'h09, 6'h00, 5'd1, 5'd5, 5'd0);
        tick();
        drv(1'b1, 6'h00, 6'h21, 5'd8, 5'd9, 5'd10);
        tick();
        drv(1'b1, 6'h00, 6'h23, 5'd5, 5'd5, 5'd7);
        tick();
        n_cmp++;
        if ({fwd_a[0], fwd_b[0]} !== 4'b0101) begin
            n_err++;
            $display("FAIL fwd_wb: got fa=%b fb=%b required 01 01", fwd_a[0], fwd_b[0]);
        end
        idle();
    endtask

    task automatic test_redirect_freeze();
        bnd_t e_o, e_a;
        logic ill;
        e_o = mdec(6'h0d, 6'h00, 5'd6, 5'd0, T, T, ill);
        e_a = mdec(6'h09, 6'h00, 5'd5, 5'd0, T, T, ill);
        idle(); tick(); tick(); tick();
        drv(1'b1, 6'h0d, 6'h00, 5'd1, 5'd6, 5'd0);
        tick();
        drv(1'b1, 6'h09, 6'h00, 5'd1, 5'd5, 5'd0);
        tick();
        drv(1'b1, 6'h00, 6'h21, 5'd1, 5'd2, 5'd3);
        freeze = 1'b1;
        redirect = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++;
            if (flush_if_id[0] !== 1'b0) begin
                n_err++;
                $display("FAIL frz_flush[%0d]: got %b required 0", k, flush_if_id[0]);
            end
            tick();
            n_cmp++;
            if ({a_ex[0], a_mem[0], a_wb[0]} !== {e_a, e_o, 24'h0}) begin
                n_err++;
                $display("FAIL frz_hold[%0d]: got %h %h %h required %h %h 0", k, a_ex[0], a_mem[0], a_wb[0], e_a, e_o);
            end
        end
        freeze = 1'b0;
        #1;
        n_cmp++;
        if (flush_if_id[0] !== 1'b1) begin
            n_err++;
            $display("FAIL rdr_flush: got %b required 1", flush_if_id[0]);
        end
        tick();
        n_cmp++;
        if ({ex_valid[0], a_mem[0], a_wb[0]} !== {F, e_a, e_o}) begin
            n_err++;
            $display("FAIL rdr_bubble: got v=%b %h %h required 0 %h %h", ex_valid[0], a_mem[0], a_wb[0], e_a, e_o);
        end
        idle();
    endtask

    task automatic test_illegal();
        idle(); tick(); tick();
        drv(1'b1, 6'h00, 6'h2a, 5'd1, 5'd2, 5'd3);
        #1;
        n_cmp++;
        if ({id_illegal[1], id_illegal[0]} !== 2'b10) begin
            n_err++;
            $display("FAIL illegal_slt: got base=%b ext=%b required 1 0", id_illegal[1], id_illegal[0]);
        end
        tick();
        n_cmp++;
        if (a_ex[1] !== '0 || ex_alu_control[0] !== 5'd4) begin
            n_err++;
            $display("FAIL illegal_bundle: got base=%h ext_alu=%0d required 0 4", a_ex[1], ex_alu_control[0]);
        end
        drv(1'b1, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0);
        #1;
        n_cmp++;
        if (id_illegal[1] !== 1'b1) begin
            n_err++;
            $display("FAIL illegal_j: got %b required 1", id_illegal[1]);
        end
        drv(1'b1, 6'h09, 6'h00, 5'd1, 5'd0, 5'd0);
        tick();
        n_cmp++;
        if ({ex_valid[0], ex_reg_write[0]} !== 2'b10) begin
            n_err++;
            $display("FAIL r0_write: got v=%b rw=%b required 1 0", ex_valid[0], ex_reg_write[0]);
        end
        idle();
    endtask

    task automatic test_async_reset();
        drv(1'b1, 6'h00, 6'h21, 5'd1, 5'd2, 5'd3);
        tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            n_cmp++;
            if ({a_ex[g], a_mem[g], a_wb[g], fwd_a[g], fwd_b[g]} !== '0) begin
                n_err++;
                $display("FAIL async_reset dut%0d: got %h %h %h required zero", g, a_ex[g], a_mem[g], a_wb[g]);
            end
        end
        tick();
        idle();
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        logic [5:0] op, fn;
        logic [AW-1:0] s, t, d;
        logic v, fr, rdr, pend, ill, haz, rtr;
        logic [1:0] fa, fb;
        bnd_t dec;
        int idx;
        reset_n = 1'b0;
        idle();
        tick();
        reset_n = 1'b1;
        mst[0] = '0; mst[1] = '0; mst[2] = '0; mfa = 2'b00; mfb = 2'b00;
        pend = 1'b0;
        for (int c = 0; c < 600; c++) begin
            idx = $urandom_range(0, 16);
            if (idx == 15) begin op = 6'h3f; fn = 6'h00; end
            else if (idx == 16) begin op = 6'h00; fn = 6'h3f; end
            else begin op = tbl[idx].op; fn = tbl[idx].fn; end
            s = AW'($urandom_range(0, 7));
            t = AW'($urandom_range(0, 7));
            d = AW'($urandom_range(0, 7));
            v = ($urandom_range(0, 7) != 0);
            fr = ($urandom_range(0, 6) == 0);
            rdr = pend ? 1'b1 : ($urandom_range(0, 5) == 0);
            drv(v, op, fn, s, t, d);
            freeze = fr;
            redirect = rdr;
            dec = mdec(op, fn, t, d, v, T, ill);
            rtr = (op == 6'h00 && fn != 6'h08) || op == 6'h2b || op == 6'h04 || op == 6'h05;
            haz = v && mst[0].valid && mst[0].m2r && mst[0].dest != 0 &&
                  (mst[0].dest == s || (rtr && mst[0].dest == t));
            fa = fsel(s);
            fb = fsel(t);
            #1;
            n_cmp++;
            if ({hazard_stall[0], flush_if_id[0], id_illegal[0]} !== {haz, rdr && !fr, ill}) begin
                n_err++;
                $display("FAIL rand_comb[%0d]: got stall/flush/ill=%b%b%b required %b%b%b", c,
                         hazard_stall[0], flush_if_id[0], id_illegal[0], haz, rdr && !fr, ill);
            end
            if (!fr) begin
                mst[2] = mst[1];
                mst[1] = mst[0];
                if (rdr || haz) begin
                    mst[0] = '0; mfa = 2'b00; mfb = 2'b00;
                end else begin
                    mst[0] = dec;
                    mfa = dec.valid ? fa : 2'b00;
                    mfb = dec.valid ? fb : 2'b00;
                end
            end
            tick();
            n_cmp++;
            if ({a_ex[0], a_mem[0], a_wb[0], fwd_a[0], fwd_b[0]} !== {mst[0], mst[1], mst[2], mfa, mfb}) begin
                n_err++;
                $display("FAIL rand_regs[%0d]: got %h %h %h %b %b required %h %h %h %b %b", c,
                         a_ex[0], a_mem[0], a_wb[0], fwd_a[0], fwd_b[0], mst[0], mst[1], mst[2], mfa, mfb);
            end
            pend = rdr && fr;
        end
        idle();
    endtask

    initial begin
        init_tbl();
        test_reset();
        test_sequence();
        test_load_use();
        test_forward();
        test_redirect_freeze();
        test_illegal();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
